// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, combinational ROM address, and a small
// registered fetch queue feeding decode, with branch redirect and illegal-PC fault.
module instr_fetch #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          IMEM_SIZE = 1024,
  parameter int          DEPTH     = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        br_taken,
  input  logic [63:0] br_target,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [63:0] id_pc,
  output logic        fetch_fault
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);
  // An aligned pc is legal iff pc + 3 < IMEM_SIZE, i.e. pc < IMEM_SIZE - 3 (no overflow).
  localparam logic [63:0] PC_LIMIT = 64'(IMEM_SIZE - 3);

  typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_t;

  state_t             state_reg, state_next;
  logic [63:0]        pc_reg, pc_next;
  logic [PTR_W:0]     count_reg, count_next;
  logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
  logic               pc_legal, enq, deq;
  logic [DEPTH-1:0]   wr_en;
  logic [31:0]        instr_q [DEPTH];
  logic [63:0]        pc_q    [DEPTH];

  always_comb begin
    pc_legal    = (pc_reg[1:0] == 2'b00) && (pc_reg < PC_LIMIT);
    deq         = (count_reg != '0) && id_ready;
    enq         = (state_reg == RUN) && pc_legal && !br_taken &&
                  ((count_reg != DEPTH_C) || deq);
    state_next  = state_reg;
    pc_next     = pc_reg;
    count_next  = count_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (br_taken) begin
      // Redirect wins over everything: flush the queue and restart from the target.
      state_next  = RUN;
      pc_next     = br_target;
      count_next  = '0;
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else begin
      if ((state_reg == RUN) && !pc_legal)
        state_next = FAULT;
      if (enq) begin
        pc_next     = pc_reg + 64'd4;
        wr_ptr_next = wr_ptr_reg + 1'b1;
      end
      if (deq)
        rd_ptr_next = rd_ptr_reg + 1'b1;
      case ({enq, deq})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= RUN;
      pc_reg     <= RESET_PC;
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      count_reg  <= count_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = enq && (wr_ptr_reg == PTR_W'(gi));
    end
  endgenerate

  // Entries are cleared on reset so the head outputs read 0 while in reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) begin
          instr_q[i] <= imem_instr;
          pc_q[i]    <= pc_reg;
        end
      end
    end
  end

  assign imem_addr   = pc_reg;
  assign id_valid    = (count_reg != '0);
  assign id_instr    = instr_q[rd_ptr_reg];
  assign id_pc       = pc_q[rd_ptr_reg];
  assign fetch_fault = (state_reg == FAULT);

endmodule
